// File: rtl/mod_mul_issue_pkg.sv
// mod_mul_issue_pkg: modulus, datapath widths and issue FSM encoding shared with the reduction stage
package mod_mul_issue_pkg;
  localparam int Q_WIDTH = 23;
  localparam int DATA_WIDTH = 48;
  localparam logic [Q_WIDTH-1:0] Q = 23'd8380417;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} issue_state_t;
endpackage

// File: rtl/mod_mul_issue_prod_fifo.sv
// prod_fifo: power-of-two product queue with combinational head and same-edge push/pop
module prod_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/mod_mul_issue.sv
// mod_mul_issue: range-checked operand multiply, product queue and one-at-a-time issue to the reducer
module mod_mul_issue #(
  parameter int DEPTH = 4,
  parameter int DATA_WIDTH = mod_mul_issue_pkg::DATA_WIDTH,
  parameter int Q_WIDTH = mod_mul_issue_pkg::Q_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [Q_WIDTH-1:0]    a,
  input  logic [Q_WIDTH-1:0]    b,
  output logic                  red_start,
  output logic [DATA_WIDTH-1:0] red_data,
  input  logic                  red_done,
  output logic                  range_err,
  output logic                  busy
);
  import mod_mul_issue_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  logic s0_valid, p_valid, accept, in_range, pop, full, empty;
  logic [Q_WIDTH-1:0] s0_a, s0_b;
  logic [DATA_WIDTH-1:0] p_data, head;
  logic [CW-1:0] count;
  issue_state_t state;
  assign accept = in_valid && in_ready;
  assign in_range = a < Q_WIDTH'(Q) && b < Q_WIDTH'(Q);
  // operand and product stages are reserved FIFO slots, so a push can never find the FIFO full
  assign in_ready = !rst && (32'(count) + 32'(s0_valid) + 32'(p_valid) < DEPTH);
  assign pop = state == IDLE && !empty;
  assign busy = s0_valid || p_valid || !empty || state == BUSY;
  prod_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(p_valid),
    .din(p_data),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_a <= '0;
      s0_b <= '0;
      p_valid <= 1'b0;
      p_data <= '0;
      range_err <= 1'b0;
    end else begin
      s0_valid <= accept && in_range;
      s0_a <= a;
      s0_b <= b;
      range_err <= range_err || (accept && !in_range);
      p_valid <= s0_valid && !full;
      p_data <= DATA_WIDTH'(s0_a) * DATA_WIDTH'(s0_b);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      red_start <= 1'b0;
      red_data <= '0;
    end else begin
      red_start <= pop;
      red_data <= pop ? head : red_data;
      state <= pop ? BUSY : (state == BUSY && red_done) ? IDLE : state;
    end
  end
endmodule

// File: tb/tb_mod_mul_issue.sv
// tb_mod_mul_issue: directed checks of issue latency, ordering, backpressure, range errors and reset
module tb_mod_mul_issue;
  logic clk = 0;
  logic rst, in_valid, in_ready, red_start, red_done, range_err, busy;
  logic [22:0] a, b;
  logic [47:0] red_data, held;
  logic [47:0] got [$];
  int n_cmp = 0, n_err = 0, stalls = 0, wait_cnt = 0, done_delay = 3;
  bit release_en = 1, inject = 0, serving = 0;

  mod_mul_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .red_start(red_start), .red_data(red_data), .red_done(red_done),
    .range_err(range_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y);
    int n = 0;
    @(negedge clk);
    in_valid = 1;
    a = 23'(x);
    b = 23'(y);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    stalls += n;
    chk("send_ready", 64'(n < 200), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic wait_got(input int n);
    int k = 0;
    while (got.size() < n && k < 500) begin
      tick;
      k++;
    end
    chk("got_count", 64'(got.size()), 64'(n));
  endtask

  task automatic wait_idle;
    int k = 0;
    while (busy && k < 500) begin
      tick;
      k++;
    end
    chk("idle", 64'(busy), 64'd0);
  endtask

  // reducer model: records each issued product, checks it holds, answers after done_delay cycles
  initial begin
    red_done = 0;
    forever begin
      @(negedge clk);
      red_done = 0;
      if (rst) serving = 0;
      else if (inject) begin
        red_done = 1;
        inject = 0;
      end else if (red_start) begin
        got.push_back(red_data);
        held = red_data;
        wait_cnt = done_delay;
        serving = 1;
      end else if (serving) begin
        chk("red_data_hold", 64'(red_data), 64'(held));
        if (wait_cnt > 0) wait_cnt--;
        else if (release_en) begin
          red_done = 1;
          serving = 0;
        end
      end
    end
  end

  initial begin
    rst = 1; in_valid = 0; a = 0; b = 0;
    repeat (3) tick;
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_red_start", 64'(red_start), 0);
    chk("rst_range_err", 64'(range_err), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_red_data", 64'(red_data), 0);
    chk("rst_count", 64'(dut.u_fifo.count), 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("ready_after_rst", 64'(in_ready), 1);

    got.delete(); done_delay = 5;
    send(2, 3);
    tick; chk("lat_e1", 64'(red_start), 0);
    tick; chk("lat_e2", 64'(red_start), 0);
    tick; chk("lat_e3", 64'(red_start), 1);
    chk("basic_data", 64'(red_data), 64'd6);
    chk("basic_busy", 64'(busy), 1);
    tick; chk("start_pulse", 64'(red_start), 0);
    wait_idle;
    chk("basic_once", 64'(got.size()), 1);

    got.delete(); done_delay = 2;
    send(8380416, 8380416);
    wait_got(1);
    chk("max_data", 64'(got[0]), 64'h3FE004000000);
    wait_idle;

    got.delete();
    send(8380417, 1);
    send(1, 8388607);
    repeat (8) tick;
    chk("oor_dropped", 64'(got.size()), 0);
    chk("oor_err", 64'(range_err), 1);
    chk("oor_busy", 64'(busy), 0);
    send(4, 5);
    wait_got(1);
    chk("oor_next", 64'(got[0]), 64'd20);
    chk("oor_sticky", 64'(range_err), 1);
    wait_idle;

    got.delete(); release_en = 0; stalls = 0;
    for (int i = 0; i < 5; i++) send(i, i + 1);
    chk("bp_no_stall", 64'(stalls), 0);
    repeat (6) tick;
    chk("bp_ready_low", 64'(in_ready), 0);
    chk("bp_fifo_full", 64'(dut.u_fifo.count), 4);
    chk("bp_one_issued", 64'(got.size()), 1);
    release_en = 1;
    send(5, 6);
    wait_got(6);
    for (int i = 0; i < 6; i++) chk($sformatf("bp_order%0d", i), 64'(got[i]), 64'(i * (i + 1)));
    wait_idle;

    got.delete(); release_en = 0; done_delay = 0;
    send(3, 3);
    send(10, 10);
    send(7, 11);
    repeat (6) tick;
    chk("pp_count_before", 64'(dut.u_fifo.count), 2);
    send(1000, 1000);
    release_en = 1;
    tick;
    tick;
    chk("pp_count_same", 64'(dut.u_fifo.count), 2);
    chk("pp_start", 64'(red_start), 1);
    chk("pp_head", 64'(red_data), 64'd100);
    wait_got(4);
    chk("pp_o0", 64'(got[0]), 64'd9);
    chk("pp_o1", 64'(got[1]), 64'd100);
    chk("pp_o2", 64'(got[2]), 64'd77);
    chk("pp_o3", 64'(got[3]), 64'd1000000);
    wait_idle;

    got.delete(); release_en = 0;
    for (int i = 2; i < 6; i++) send(i, i);
    repeat (6) tick;
    chk("mr_queued", 64'(dut.u_fifo.count), 3);
    chk("mr_busy", 64'(busy), 1);
    @(negedge clk);
    rst = 1;
    tick;
    chk("mr_in_ready", 64'(in_ready), 0);
    chk("mr_red_start", 64'(red_start), 0);
    chk("mr_range_err", 64'(range_err), 0);
    chk("mr_busy0", 64'(busy), 0);
    chk("mr_red_data", 64'(red_data), 0);
    chk("mr_count", 64'(dut.u_fifo.count), 0);
    @(negedge clk);
    rst = 0;
    got.delete();
    inject = 1;
    repeat (10) tick;
    chk("mr_no_start", 64'(got.size()), 0);
    chk("mr_idle", 64'(busy), 0);
    chk("mr_ready", 64'(in_ready), 1);
    release_en = 1;
    send(6, 7);
    wait_got(1);
    chk("mr_resume", 64'(got[0]), 64'd42);
    wait_idle;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mod_mul_issue.md
MOD_MUL_ISSUE -- requirements
Module: mod_mul_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, product FIFO depth (power of two, at least 2).
REQ-002 SHALL have parameter DATA_WIDTH, default 48, product width delivered to the reduction stage.
REQ-003 SHALL have parameter Q_WIDTH, default 23, operand width.
REQ-004 SHALL have port clk  input  1  single clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have ports in_valid  input  1 and in_ready  output  1, the operand handshake.
REQ-007 SHALL have ports a and b, each input  Q_WIDTH, the operands.
REQ-008 SHALL have port red_start  output  1, one-cycle start pulse to the downstream reducer.
REQ-009 SHALL have port red_data  output  DATA_WIDTH, the product held stable from red_start until red_done.
REQ-010 SHALL have port red_done  input  1, the reducer completion pulse.
REQ-011 SHALL have port range_err  output  1, sticky flag: an operand was at or above Q.
REQ-012 SHALL have port busy  output  1, high while any product is in the pipe, the FIFO, or the reducer.

Function
REQ-013 SHALL accept an operand pair on any rising edge where in_valid and in_ready are both high.
REQ-014 SHALL drive in_ready high only when FIFO occupancy plus in-flight multiplier products is less than DEPTH.
REQ-015 SHALL drop an accepted pair whose a or b is at or above Q = 8380417, and SHALL set range_err until reset.
REQ-016 SHALL register the zero-extended product a*b (at most 46 significant bits) one edge after acceptance.
REQ-017 SHALL write that product into the FIFO on the following edge.
REQ-018 SHALL give the issue FSM two states, IDLE and BUSY.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop the FIFO head into red_data, pulse red_start for exactly one cycle, and enter BUSY, all on the same edge.
REQ-020 In BUSY, the FSM SHALL hold red_data and keep red_start low.
REQ-021 In BUSY, red_done sampled high SHALL move the FSM to IDLE; the earliest next red_start is one edge later.
REQ-022 SHALL ignore red_done while in IDLE.
REQ-023 Minimum latency SHALL be 3 edges from acceptance to red_start high (empty FIFO, FSM IDLE).
REQ-024 SHALL deliver products in strict acceptance order.
REQ-025 SHALL allow a FIFO push and pop on the same edge; occupancy stays unchanged and no data is lost.
REQ-026 With the FIFO full, in_ready SHALL already be low, so no overflow occurs; a pop frees one slot, and in_ready rises on the next cycle.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 On reset, in_ready, red_start, range_err and busy SHALL be 0, red_data SHALL be all zeros, the FSM SHALL be IDLE, and FIFO pointers and count SHALL be 0.
REQ-029 Reset mid-operation SHALL discard all in-flight and queued products; a red_done arriving after reset SHALL be ignored.
REQ-030 in_ready SHALL rise on the first cycle after reset deasserts.

Structure
REQ-031 Q (8380417), Q_WIDTH, DATA_WIDTH and the FSM state encoding SHALL live in a shared package used by the reduction stage as well.
REQ-032 The FIFO SHALL be a separate sub-module named prod_fifo, with DEPTH and width parameters and push, pop, full, empty and count ports.

Verification
REQ-033 Basic path: a=2, b=3, red_done returned 6 cycles after red_start -> red_start rises 3 edges after acceptance with red_data=6, and busy falls after red_done.
REQ-034 Max operands: a=b=8380416 -> red_data=0x3FE004000000 (70231372333056).
REQ-035 Out of range: a=8380417, b=1 -> no red_start occurs, range_err=1 until reset, and the next valid pair is processed normally.
REQ-036 Backpressure: 6 back-to-back pairs (i, i+1) for i=0..5 with red_done withheld -> in_ready drops after 4 products are in flight; after each red_done, red_data sequence is 0, 2, 6, 12, 20, 30.
REQ-037 Simultaneous push and pop: with the FIFO holding 2 entries, accept a new pair on the same edge a pop occurs -> count stays 2 and order is preserved.
REQ-038 Reset in BUSY with 3 queued products -> all outputs at reset values, and a later red_done produces no red_start.
